// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU encodings: aluControl codes, ALUOp classes and funct3 values.
// Imported by the issue stage and by the reusable alu_control decoder.
package alu_defs;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_BAD = 4'b1111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and EX-side bundle of the ALU issue stage.
// master = decode/EX environment, slave = the issue stage itself.
interface alu_issue_stage_if #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [XLEN-1:0]       rs1_data;
   logic [XLEN-1:0]       rs2_data;
   logic [XLEN-1:0]       imm;
   logic                  alu_src;
   logic [1:0]            alu_op;
   logic [2:0]            funct3;
   logic                  funct7_b5;
   logic [REG_ADDR_W-1:0] rd;
   logic                  reg_write;
   logic                  mem_read;
   logic                  mem_write;
   logic                  mem_to_reg;
   logic                  branch;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       X;
   logic [XLEN-1:0]       Y;
   logic [3:0]            aluControl;
   logic [XLEN-1:0]       store_data;
   logic [REG_ADDR_W-1:0] rd_o;
   logic                  reg_write_o;
   logic                  mem_read_o;
   logic                  mem_write_o;
   logic                  mem_to_reg_o;
   logic                  branch_o;
   logic                  illegal;
   logic [31:0]           issue_cnt;
   logic [31:0]           stall_cnt;

   modport master (
      output flush, in_valid, rs1_data, rs2_data, imm, alu_src,
             alu_op, funct3, funct7_b5, rd, reg_write, mem_read,
             mem_write, mem_to_reg, branch, out_ready,
      input  in_ready, out_valid, X, Y, aluControl, store_data,
             rd_o, reg_write_o, mem_read_o, mem_write_o,
             mem_to_reg_o, branch_o, illegal, issue_cnt, stall_cnt
   );

   modport slave (
      input  flush, in_valid, rs1_data, rs2_data, imm, alu_src,
             alu_op, funct3, funct7_b5, rd, reg_write, mem_read,
             mem_write, mem_to_reg, branch, out_ready,
      output in_ready, out_valid, X, Y, aluControl, store_data,
             rd_o, reg_write_o, mem_read_o, mem_write_o,
             mem_to_reg_o, branch_o, illegal, issue_cnt, stall_cnt
   );

endinterface

// File: rtl/alu_issue_stage_control.sv
// Combinational ALU function decode: (alu_op, funct3, funct7_b5) -> code.
// Unsupported encodings yield ALU_BAD with illegal set.
module alu_control
   import alu_defs::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);

   always_comb begin
      alu_ctrl = ALU_BAD;
      illegal  = 1'b1;
      unique case (alu_op)
         ALUOP_MEM: begin
            alu_ctrl = ALU_ADD;
            illegal  = 1'b0;
         end
         ALUOP_BR: begin
            alu_ctrl = ALU_SUB;
            illegal  = 1'b0;
         end
         ALUOP_R: begin
            case (funct3)
               F3_ADD: begin
                  alu_ctrl = funct7_b5 ? ALU_SUB : ALU_ADD;
                  illegal  = 1'b0;
               end
               F3_AND: begin
                  alu_ctrl = ALU_AND;
                  illegal  = 1'b0;
               end
               F3_OR: begin
                  alu_ctrl = ALU_OR;
                  illegal  = 1'b0;
               end
               default: ;
            endcase
         end
         ALUOP_I: begin
            // no SUBI in RV64I, so bit 30 is part of the immediate here
            case (funct3)
               F3_ADD: begin
                  alu_ctrl = ALU_ADD;
                  illegal  = 1'b0;
               end
               F3_AND: begin
                  alu_ctrl = ALU_AND;
                  illegal  = 1'b0;
               end
               F3_OR: begin
                  alu_ctrl = ALU_OR;
                  illegal  = 1'b0;
               end
               default: ;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand/aluControl formation into a 2-entry skid buffer.
// Define ALU_ISSUE_PERF_EN to build the issue/stall performance counters.
module alu_issue_stage
   import alu_defs::*;
#(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   alu_issue_stage_if.slave    bus
);

   typedef struct packed {
      logic [XLEN-1:0]       x;
      logic [XLEN-1:0]       y;
      logic [XLEN-1:0]       store_data;
      logic [3:0]            ctrl;
      logic                  illegal;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  branch;
   } entry_t;

   entry_t in_entry;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   [3:0] dec_ctrl;
   logic   dec_illegal;
   logic   accept;
   logic   out_free;

   alu_control u_alu_control (
      .alu_op    (bus.alu_op),
      .funct3    (bus.funct3),
      .funct7_b5 (bus.funct7_b5),
      .alu_ctrl  (dec_ctrl),
      .illegal   (dec_illegal)
   );

   always_comb begin
      in_entry            = '0;
      in_entry.x          = bus.rs1_data;
      in_entry.y          = bus.alu_src ? bus.imm : bus.rs2_data;
      in_entry.store_data = bus.rs2_data;
      in_entry.ctrl       = dec_ctrl;
      in_entry.illegal    = dec_illegal;
      in_entry.rd         = bus.rd;
      in_entry.reg_write  = bus.reg_write & ~dec_illegal;
      in_entry.mem_read   = bus.mem_read;
      in_entry.mem_write  = bus.mem_write;
      in_entry.mem_to_reg = bus.mem_to_reg;
      in_entry.branch     = bus.branch;
   end

   // ready depends only on the skid flop (and reset), never on out_ready
   assign bus.in_ready = ~skid_valid_q & ~rst;
   assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
   assign out_free     = ~out_valid_q | bus.out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = accept;
            if (accept) skid_d = in_entry;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = in_entry;
         end
      end else if (accept) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.X            = out_q.x;
   assign bus.Y            = out_q.y;
   assign bus.store_data   = out_q.store_data;
   assign bus.aluControl   = out_q.ctrl;
   assign bus.illegal      = out_q.illegal;
   assign bus.rd_o         = out_q.rd;
   assign bus.reg_write_o  = out_q.reg_write;
   assign bus.mem_read_o   = out_q.mem_read;
   assign bus.mem_write_o  = out_q.mem_write;
   assign bus.mem_to_reg_o = out_q.mem_to_reg;
   assign bus.branch_o     = out_q.branch;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q & bus.out_ready) issue_cnt_d = issue_cnt_q + 32'd1;
      if (out_valid_q & ~bus.out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.issue_cnt = issue_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.issue_cnt = 32'd0;
   assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Counter expectations follow ALU_ISSUE_PERF_EN as defined at compile time.
module tb_alu_issue_stage;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_issue_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

   alu_issue_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op,
                        input logic [2:0] f3, input logic f7,
                        input logic src, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im,
                        input logic [4:0] rd, input logic rw);
      bus.in_valid  = v;
      bus.alu_op    = op;
      bus.funct3    = f3;
      bus.funct7_b5 = f7;
      bus.alu_src   = src;
      bus.rs1_data  = a;
      bus.rs2_data  = b;
      bus.imm       = im;
      bus.rd        = rd;
      bus.reg_write = rw;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid);
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready);
      end
      total++;
      if (bus.X !== 64'd0 || bus.Y !== 64'd0 || bus.aluControl !== 4'b0000) begin
         bad++;
         $display("FAIL reset_data got X=%0h Y=%0h ctl=%0b want 0/0/0000",
                  bus.X, bus.Y, bus.aluControl);
      end
      total++;
      if (bus.reg_write_o !== 1'b0 || bus.illegal !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl got rw=%0b ill=%0b want 0/0",
                         bus.reg_write_o, bus.illegal);
      end
      tick();
      rst = 1'b0;
      tick();
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL post_reset got rdy=%0b vld=%0b want 1/0",
                         bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_add();
      bus.out_ready = 1'b1;
      drive(1, 2'b10, 3'b000, 0, 0, 64'd123, 64'd321, 64'd0, 5'd7, 1);
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.X !== 64'd123 || bus.Y !== 64'd321) begin
         bad++; $display("FAIL add_ops got vld=%0b X=%0d Y=%0d want 1/123/321",
                         bus.out_valid, bus.X, bus.Y);
      end
      total++;
      if (bus.aluControl !== 4'b0010 || bus.X + bus.Y !== 64'd444) begin
         bad++; $display("FAIL add_ctl got ctl=%0b sum=%0d want 0010/444",
                         bus.aluControl, bus.X + bus.Y);
      end
      total++;
      if (bus.store_data !== 64'd321 || bus.rd_o !== 5'd7 ||
          bus.reg_write_o !== 1'b1 || bus.illegal !== 1'b0) begin
         bad++; $display("FAIL add_pass got sd=%0d rd=%0d rw=%0b ill=%0b want 321/7/1/0",
                         bus.store_data, bus.rd_o, bus.reg_write_o, bus.illegal);
      end
      bus.in_valid = 1'b0;
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL add_drain got vld=%0b want 0", bus.out_valid);
      end
   endtask

   task automatic test_or_imm();
      bus.out_ready = 1'b1;
      drive(1, 2'b11, 3'b110, 1, 1, 64'h0000AAAA, 64'h5,
            64'hAAAA0000, 5'd3, 1);
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.aluControl !== 4'b0001 || bus.illegal !== 1'b0) begin
         bad++; $display("FAIL or_ctl got ctl=%0b ill=%0b want 0001/0",
                         bus.aluControl, bus.illegal);
      end
      total++;
      if (bus.X !== 64'h0000AAAA || bus.Y !== 64'hAAAA0000 ||
          bus.store_data !== 64'h5) begin
         bad++; $display("FAIL or_ops got X=%0h Y=%0h sd=%0h want aaaa/aaaa0000/5",
                         bus.X, bus.Y, bus.store_data);
      end
      tick();
   endtask

   task automatic test_decode_table();
      logic [1:0] ops [9]  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b11, 2'b11, 2'b10};
      logic [2:0] f3s [9]  = '{3'b101, 3'b011, 3'b000, 3'b111, 3'b110,
                               3'b000, 3'b111, 3'b001, 3'b010};
      logic       f7s [9]  = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
      logic [3:0] ctl [9]  = '{4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001,
                               4'b0010, 4'b0000, 4'b1111, 4'b1111};
      logic       ill [9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(1, ops[i], f3s[i], f7s[i], 0, 64'(i), 64'd1, 64'd0, 5'd1, 1);
         tick();
         total++;
         if (bus.aluControl !== ctl[i] || bus.illegal !== ill[i] ||
             bus.X !== 64'(i) || bus.reg_write_o !== !ill[i]) begin
            bad++;
            $display("FAIL decode_%0d got ctl=%0b ill=%0b X=%0d rw=%0b want %0b/%0b/%0d/%0b",
                     i, bus.aluControl, bus.illegal, bus.X, bus.reg_write_o,
                     ctl[i], ill[i], i, !ill[i]);
         end
      end
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      drive(1, 2'b10, 3'b100, 0, 0, 64'd1, 64'd2, 64'd0, 5'd9, 1);
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.aluControl !== 4'b1111 ||
          bus.illegal !== 1'b1 || bus.reg_write_o !== 1'b0 || bus.rd_o !== 5'd9) begin
         bad++;
         $display("FAIL illegal got vld=%0b ctl=%0b ill=%0b rw=%0b rd=%0d want 1/1111/1/0/9",
                  bus.out_valid, bus.aluControl, bus.illegal, bus.reg_write_o, bus.rd_o);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [63:0] a [3] = '{64'd128, 64'd12345, 64'd6};
      logic [63:0] b [3] = '{64'd64, 64'd2345, 64'd3};
      logic [63:0] d [3] = '{64'd64, 64'd10000, 64'd3};
      bus.out_ready = 1'b0;
      drive(1, 2'b10, 3'b000, 1, 0, a[0], b[0], 64'd0, 5'd1, 1);
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.X !== a[0] || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_first got vld=%0b X=%0d rdy=%0b want 1/128/1",
                         bus.out_valid, bus.X, bus.in_ready);
      end
      drive(1, 2'b10, 3'b000, 1, 0, a[1], b[1], 64'd0, 5'd2, 1);
      tick();
      total++;
      if (bus.in_ready !== 1'b0 || bus.X !== a[0] || bus.Y !== b[0]) begin
         bad++; $display("FAIL bp_full got rdy=%0b X=%0d Y=%0d want 0/128/64",
                         bus.in_ready, bus.X, bus.Y);
      end
      drive(1, 2'b10, 3'b000, 1, 0, a[2], b[2], 64'd0, 5'd3, 1);
      tick();
      total++;
      if (bus.in_ready !== 1'b0 || bus.X !== a[0] || bus.rd_o !== 5'd1) begin
         bad++; $display("FAIL bp_hold got rdy=%0b X=%0d rd=%0d want 0/128/1",
                         bus.in_ready, bus.X, bus.rd_o);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin
            total++;
            if (bus.X - bus.Y !== d[0] || bus.aluControl !== 4'b0110) begin
               bad++; $display("FAIL bp_out_0 got diff=%0d ctl=%0b want %0d/0110",
                               bus.X - bus.Y, bus.aluControl, d[0]);
            end
         end else begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.X !== a[i] || bus.Y !== b[i] ||
                bus.X - bus.Y !== d[i]) begin
               bad++; $display("FAIL bp_out_%0d got vld=%0b X=%0d Y=%0d want 1/%0d/%0d",
                               i, bus.out_valid, bus.X, bus.Y, a[i], b[i]);
            end
         end
         tick();
         if (i == 1) bus.in_valid = 1'b0;
      end
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_drain got vld=%0b want 0", bus.out_valid);
      end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive(1, 2'b00, 3'b000, 0, 0, 64'd1, 64'd2, 64'd0, 5'd1, 1);
      tick();
      drive(1, 2'b00, 3'b000, 0, 0, 64'd3, 64'd4, 64'd0, 5'd2, 1);
      tick();
      drive(1, 2'b00, 3'b000, 0, 0, 64'd5, 64'd6, 64'd0, 5'd3, 1);
      bus.flush = 1'b1;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL flush_full got vld=%0b rdy=%0b want 0/1",
                         bus.out_valid, bus.in_ready);
      end
      drive(1, 2'b00, 3'b000, 0, 0, 64'd7, 64'd8, 64'd0, 5'd4, 1);
      tick();
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL flush_drop got vld=%0b X=%0d want 0",
                         bus.out_valid, bus.X);
      end
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL flush_after got vld=%0b rdy=%0b want 0/1",
                         bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] exp_issue;
      logic [31:0] exp_stall;
`ifdef ALU_ISSUE_PERF_EN
      exp_issue = 32'd4;
      exp_stall = 32'd3;
`else
      exp_issue = 32'd0;
      exp_stall = 32'd0;
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(1, 2'b00, 3'b000, 0, 0, 64'(i), 64'd0, 64'd0, 5'd1, 1);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.X !== 64'd5) begin
         bad++; $display("FAIL stall_hold got vld=%0b X=%0d want 1/5",
                         bus.out_valid, bus.X);
      end
      total++;
      if (bus.issue_cnt !== exp_issue || bus.stall_cnt !== exp_stall) begin
         bad++; $display("FAIL perf_cnt got issue=%0d stall=%0d want %0d/%0d",
                         bus.issue_cnt, bus.stall_cnt, exp_issue, exp_stall);
      end
      #3 rst = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.X !== 64'd0) begin
         bad++; $display("FAIL async_rst got vld=%0b rdy=%0b X=%0d want 0/0/0",
                         bus.out_valid, bus.in_ready, bus.X);
      end
      total++;
      if (bus.issue_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin
         bad++; $display("FAIL perf_rst got issue=%0d stall=%0d want 0/0",
                         bus.issue_cnt, bus.stall_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_release got vld=%0b rdy=%0b want 0/1",
                         bus.out_valid, bus.in_ready);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      clk           = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.branch    = 1'b0;
      drive(0, 2'b00, 3'b000, 0, 0, 64'd0, 64'd0, 64'd0, 5'd0, 0);
      test_reset();
      test_add();
      test_or_imm();
      test_decode_table();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
